// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the barrel shift sequencer, the shifter wrapper and the benches.
// Optional build macro used by the sequencer: BARREL_SEQ_WRAP_EN.
package barrel_shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int COUNT_W = SHAMT_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Requests longer than one full sweep of the operand are cut down to DATA_W beats
    function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] count);
        return (count > COUNT_W'(DATA_W)) ? COUNT_W'(DATA_W) : count;
    endfunction

endpackage

// File: rtl/barrel_shift_sequencer_if.sv
// Command and beat handshake bundle between the sequencer and its neighbours.
// The slave modport is the sequencer side; the master modport drives commands and sinks beats.
interface barrel_shift_sequencer_if;
    import barrel_shift_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [DATA_W-1:0]  cmd_data;
    logic [SHAMT_W-1:0] cmd_start_shamt;
    logic [COUNT_W-1:0] cmd_count;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_a;
    logic [SHAMT_W-1:0] out_shift;
    logic               out_last;
    logic               busy;

    modport slave (
        input  cmd_valid, cmd_data, cmd_start_shamt, cmd_count, out_ready,
        output cmd_ready, out_valid, out_a, out_shift, out_last, busy
    );

    modport master (
        output cmd_valid, cmd_data, cmd_start_shamt, cmd_count, out_ready,
        input  cmd_ready, out_valid, out_a, out_shift, out_last, busy
    );

endinterface

// File: rtl/barrel_shift_sequencer.sv
// Barrel shift sequencer: turns one (operand, start shift, count) command into a stream
// of (operand, shift) beats for the left barrel shifter, shift incrementing per beat.
// Build macro BARREL_SEQ_WRAP_EN: when defined the shift wraps from DATA_W-1 to 0 and the
// command always yields min(count, DATA_W) beats; when undefined the run stops at DATA_W-1.
module barrel_shift_sequencer
    import barrel_shift_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    barrel_shift_sequencer_if.slave   bus
);

`ifdef BARREL_SEQ_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    seq_state_t         r_state;
    seq_state_t         w_stateNext;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  w_aNext;
    logic [SHAMT_W-1:0] r_cur;
    logic [SHAMT_W-1:0] w_curNext;
    logic [COUNT_W-1:0] r_rem;
    logic [COUNT_W-1:0] w_remNext;
    logic               r_last;
    logic               w_lastNext;
    logic               r_cmdReady;
    logic               r_outValid;
    logic               r_busy;

    logic               w_cmdFire;
    logic               w_beatFire;
    logic               w_cmdLoad;
    logic [COUNT_W-1:0] w_countClamped;
    logic [SHAMT_W-1:0] w_curInc;
    logic [COUNT_W-1:0] w_remDec;

    // cmd_ready is itself a register, so accepting a command never depends on a combinational
    // decode; a zero-length command is consumed here but never loads the run registers.
    assign w_cmdFire      = bus.cmd_valid && r_cmdReady;
    assign w_beatFire     = r_outValid && bus.out_ready;
    assign w_countClamped = clamp_count(bus.cmd_count);
    assign w_cmdLoad      = w_cmdFire && (w_countClamped != '0);
    assign w_curInc       = r_cur + SHAMT_W'(1);
    assign w_remDec       = r_rem - COUNT_W'(1);

    // State register; an asynchronous reset abandons any beat in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: start a run on a non-empty command, finish when the last beat transfers
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmdLoad) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (w_beatFire && r_last) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Next beat contents: load from the command, advance on each transfer, hold while stalled;
    // last is precomputed one beat ahead so out_last can come straight from a flop
    always_comb begin
        w_aNext    = r_a;
        w_curNext  = r_cur;
        w_remNext  = r_rem;
        w_lastNext = r_last;
        case (r_state)
            IDLE: begin
                if (w_cmdLoad) begin
                    w_aNext    = bus.cmd_data;
                    w_curNext  = bus.cmd_start_shamt;
                    w_remNext  = w_countClamped;
                    w_lastNext = (w_countClamped == COUNT_W'(1)) ||
                                 (!WRAP_EN && (bus.cmd_start_shamt == SHAMT_W'(DATA_W - 1)));
                end
            end
            RUN: begin
                if (w_beatFire) begin
                    if (r_last) begin
                        w_lastNext = 1'b0;
                    end else begin
                        w_curNext  = w_curInc;
                        w_remNext  = w_remDec;
                        w_lastNext = (w_remDec == COUNT_W'(1)) ||
                                     (!WRAP_EN && (w_curInc == SHAMT_W'(DATA_W - 1)));
                    end
                end
            end
            default: begin
                w_lastNext = 1'b0;
            end
        endcase
    end

    // Output and datapath registers, all driven from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_cur      <= '0;
            r_rem      <= '0;
            r_last     <= 1'b0;
            r_cmdReady <= 1'b0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_a        <= w_aNext;
            r_cur      <= w_curNext;
            r_rem      <= w_remNext;
            r_last     <= w_lastNext;
            r_cmdReady <= (w_stateNext == IDLE);
            r_outValid <= (w_stateNext == RUN);
            r_busy     <= (w_stateNext == RUN);
        end
    end

    assign bus.cmd_ready = r_cmdReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_a     = r_a;
    assign bus.out_shift = r_cur;
    assign bus.out_last  = r_last;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Directed bench for barrel_shift_sequencer: sweep, wrap boundary, backpressure,
// zero/clamp counts, reset mid-run and busy rejection. Honours BARREL_SEQ_WRAP_EN.
module tb_barrel_shift_sequencer;
    import barrel_shift_pkg::*;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFails;

    logic [SHAMT_W-1:0] capShift [64];
    logic [DATA_W-1:0]  capA     [64];
    logic               capLast  [64];
    int                 capN;

    barrel_shift_sequencer_if bus();

    barrel_shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offer a command from a falling edge and return on the falling edge after it is taken
    task automatic issueCmd(input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s,
                            input logic [COUNT_W-1:0] c);
        int k;
        bus.cmd_data        = d;
        bus.cmd_start_shamt = s;
        bus.cmd_count       = c;
        bus.cmd_valid       = 1'b1;
        k = 0;
        while (!bus.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        nChecks++;
        if (!bus.cmd_ready) begin
            nFails++;
            $display("[TB] FAIL cmd_accept_timeout: cmd_ready=%0b required 1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Record every transferred beat until the last one, within a cycle budget
    task automatic collectBeats(input int maxCycles);
        capN = 0;
        for (int k = 0; k < maxCycles; k++) begin
            if (bus.out_valid && bus.out_ready) begin
                if (capN < 64) begin
                    capShift[capN] = bus.out_shift;
                    capA[capN]     = bus.out_a;
                    capLast[capN]  = bus.out_last;
                end
                capN++;
                if (bus.out_last) begin
                    @(negedge clk);
                    return;
                end
            end
            @(negedge clk);
        end
        nChecks++;
        nFails++;
        $display("[TB] FAIL beat_timeout: no last beat within %0d cycles, beats=%0d", maxCycles, capN);
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_start_shamt = '0;
        bus.cmd_count = '0;   bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", bus.out_valid); end
        nChecks++; if (bus.out_a !== '0) begin nFails++; $display("[TB] FAIL reset_a: got %h want 0", bus.out_a); end
        nChecks++; if (bus.out_shift !== '0) begin nFails++; $display("[TB] FAIL reset_shift: got %0d want 0", bus.out_shift); end
        nChecks++; if (bus.out_last !== 1'b0) begin nFails++; $display("[TB] FAIL reset_last: got %b want 0", bus.out_last); end
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        nChecks++; if (bus.cmd_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
        repeat (3) @(negedge clk);
        nChecks++; if (bus.cmd_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_hold_ready: got %b want 0", bus.cmd_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++; if (bus.cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_full_sweep();
        bus.out_ready = 1'b1;
        issueCmd(32'h2D93_FB1A, 5'd0, 6'd32);
        collectBeats(100);
        nChecks++; if (capN !== 32) begin nFails++; $display("[TB] FAIL sweep_count: got %0d beats want 32", capN); end
        for (int i = 0; i < 32 && i < capN; i++) begin
            nChecks++; if (capShift[i] !== SHAMT_W'(i)) begin nFails++; $display("[TB] FAIL sweep_shift[%0d]: got %0d want %0d", i, capShift[i], i); end
            nChecks++; if (capA[i] !== 32'h2D93_FB1A) begin nFails++; $display("[TB] FAIL sweep_a[%0d]: got %h want 2d93fb1a", i, capA[i]); end
            nChecks++; if (capLast[i] !== (i == 31)) begin nFails++; $display("[TB] FAIL sweep_last[%0d]: got %b want %b", i, capLast[i], (i == 31)); end
        end
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL sweep_end_valid: got %b want 0", bus.out_valid); end
        nChecks++; if (bus.cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL sweep_end_ready: got %b want 1", bus.cmd_ready); end
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL sweep_end_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_wrap_boundary();
        logic [SHAMT_W-1:0] expShift [4];
        int expN;
`ifdef BARREL_SEQ_WRAP_EN
        expN = 4;
        expShift[0] = 5'd30; expShift[1] = 5'd31; expShift[2] = 5'd0; expShift[3] = 5'd1;
`else
        expN = 2;
        expShift[0] = 5'd30; expShift[1] = 5'd31; expShift[2] = 5'd0; expShift[3] = 5'd0;
`endif
        bus.out_ready = 1'b1;
        issueCmd(32'hA5A5_0F0F, 5'd30, 6'd4);
        collectBeats(50);
        nChecks++; if (capN !== expN) begin nFails++; $display("[TB] FAIL wrap_count: got %0d beats want %0d", capN, expN); end
        for (int i = 0; i < expN && i < capN; i++) begin
            nChecks++; if (capShift[i] !== expShift[i]) begin nFails++; $display("[TB] FAIL wrap_shift[%0d]: got %0d want %0d", i, capShift[i], expShift[i]); end
            nChecks++; if (capLast[i] !== (i == expN - 1)) begin nFails++; $display("[TB] FAIL wrap_last[%0d]: got %b want %b", i, capLast[i], (i == expN - 1)); end
        end
    endtask

    task automatic test_backpressure();
        int k;
        bus.out_ready = 1'b1;
        issueCmd(32'h1234_5678, 5'd0, 6'd8);
        k = 0;
        while (!(bus.out_valid && bus.out_shift == 5'd2) && k < 20) begin
            @(negedge clk);
            k++;
        end
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            nChecks++; if (bus.out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL stall_valid[%0d]: got %b want 1", c, bus.out_valid); end
            nChecks++; if (bus.out_shift !== 5'd2) begin nFails++; $display("[TB] FAIL stall_shift[%0d]: got %0d want 2", c, bus.out_shift); end
            nChecks++; if (bus.out_a !== 32'h1234_5678) begin nFails++; $display("[TB] FAIL stall_a[%0d]: got %h want 12345678", c, bus.out_a); end
            nChecks++; if (bus.out_last !== 1'b0) begin nFails++; $display("[TB] FAIL stall_last[%0d]: got %b want 0", c, bus.out_last); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        collectBeats(30);
        nChecks++; if (capN !== 5) begin nFails++; $display("[TB] FAIL resume_count: got %0d beats want 5", capN); end
        for (int i = 0; i < 5 && i < capN; i++) begin
            nChecks++; if (capShift[i] !== SHAMT_W'(i + 3)) begin nFails++; $display("[TB] FAIL resume_shift[%0d]: got %0d want %0d", i, capShift[i], i + 3); end
        end
        nChecks++; if (capN > 0 && capLast[capN-1] !== 1'b1) begin nFails++; $display("[TB] FAIL resume_last: got %b want 1", capLast[capN-1]); end
    endtask

    task automatic test_zero_clamp();
        bus.out_ready = 1'b1;
        issueCmd(32'hDEAD_BEEF, 5'd0, 6'd0);
        for (int c = 0; c < 3; c++) begin
            nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL zero_valid[%0d]: got %b want 0", c, bus.out_valid); end
            nChecks++; if (bus.cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL zero_ready[%0d]: got %b want 1", c, bus.cmd_ready); end
            @(negedge clk);
        end
        issueCmd(32'hCAFE_F00D, 5'd0, 6'd40);
        collectBeats(100);
        nChecks++; if (capN !== 32) begin nFails++; $display("[TB] FAIL clamp_count: got %0d beats want 32", capN); end
        nChecks++; if (capN > 0 && capShift[capN-1] !== 5'd31) begin nFails++; $display("[TB] FAIL clamp_final_shift: got %0d want 31", capShift[capN-1]); end
    endtask

    task automatic test_reset_mid_run();
        int k;
        bus.out_ready = 1'b1;
        issueCmd(32'h0F0F_F0F0, 5'd0, 6'd10);
        k = 0;
        while (!(bus.out_valid && bus.out_shift == 5'd5) && k < 20) begin
            @(negedge clk);
            k++;
        end
        nChecks++; if (bus.out_shift !== 5'd5) begin nFails++; $display("[TB] FAIL midrun_reach: got %0d want 5", bus.out_shift); end
        #1 rst_n = 1'b0;
        #1;
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL midrun_valid: got %b want 0", bus.out_valid); end
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL midrun_busy: got %b want 0", bus.busy); end
        nChecks++; if (bus.out_shift !== '0) begin nFails++; $display("[TB] FAIL midrun_shift: got %0d want 0", bus.out_shift); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nChecks++; if (bus.cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL midrun_ready: got %b want 1", bus.cmd_ready); end
        issueCmd(32'h7777_1111, 5'd3, 6'd2);
        collectBeats(20);
        nChecks++; if (capN !== 2) begin nFails++; $display("[TB] FAIL after_reset_count: got %0d want 2", capN); end
        nChecks++; if (capShift[0] !== 5'd3) begin nFails++; $display("[TB] FAIL after_reset_shift0: got %0d want 3", capShift[0]); end
        nChecks++; if (capShift[1] !== 5'd4 || capLast[1] !== 1'b1) begin nFails++; $display("[TB] FAIL after_reset_beat1: shift %0d last %b want 4/1", capShift[1], capLast[1]); end
        nChecks++; if (capA[0] !== 32'h7777_1111) begin nFails++; $display("[TB] FAIL after_reset_a: got %h want 77771111", capA[0]); end
    endtask

    task automatic test_back_to_back();
        int n;
        int k;
        bus.out_ready = 1'b1;
        issueCmd(32'h1111_2222, 5'd0, 6'd4);
        bus.cmd_data = 32'h3333_4444; bus.cmd_start_shamt = 5'd10; bus.cmd_count = 6'd2;
        bus.cmd_valid = 1'b1;
        n = 0;
        k = 0;
        while (k < 20) begin
            if (bus.out_valid) begin
                nChecks++; if (bus.cmd_ready !== 1'b0) begin nFails++; $display("[TB] FAIL busy_ready[%0d]: got %b want 0", n, bus.cmd_ready); end
                nChecks++; if (bus.out_shift !== SHAMT_W'(n)) begin nFails++; $display("[TB] FAIL busy_shift[%0d]: got %0d want %0d", n, bus.out_shift, n); end
                n++;
                if (bus.out_last) begin
                    k = 20;
                end
            end
            @(negedge clk);
            k++;
        end
        nChecks++; if (n !== 4) begin nFails++; $display("[TB] FAIL busy_first_count: got %0d want 4", n); end
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL gap_valid: got %b want 0", bus.out_valid); end
        nChecks++; if (bus.cmd_ready !== 1'b1) begin nFails++; $display("[TB] FAIL gap_ready: got %b want 1", bus.cmd_ready); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        nChecks++; if (bus.out_valid !== 1'b1) begin nFails++; $display("[TB] FAIL second_latency: got %b want 1", bus.out_valid); end
        collectBeats(20);
        nChecks++; if (capN !== 2) begin nFails++; $display("[TB] FAIL second_count: got %0d want 2", capN); end
        nChecks++; if (capShift[0] !== 5'd10 || capShift[1] !== 5'd11) begin nFails++; $display("[TB] FAIL second_shifts: got %0d,%0d want 10,11", capShift[0], capShift[1]); end
        nChecks++; if (capA[0] !== 32'h3333_4444 || capLast[1] !== 1'b1) begin nFails++; $display("[TB] FAIL second_data: a %h last %b want 33334444/1", capA[0], capLast[1]); end
    endtask

    // Scenario sequence and summary
    initial begin
        nChecks = 0;
        nFails  = 0;
        capN    = 0;
        $display("[TB] barrel_shift_sequencer directed test start");
        test_reset();
        test_full_sweep();
        test_wrap_boundary();
        test_backpressure();
        test_zero_clamp();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
